// File: rtl/fft_out_serializer.sv
// ============================================================================
// Module   : fft_out_serializer
// Purpose  : Ping-pong parallel-to-serial buffer for a 32-point complex FFT
//            frame. A whole frame is captured in one handshake and streamed
//            out one complex sample per beat. The read order is either
//            natural or 5-bit bit-reversed, selected by ORDER.
// Ports    : clk                     - single rising-edge clock
//            rst                     - asynchronous reset, active low
//            in_valid / in_ready     - frame handshake (capture on both high)
//            in1_r..in32_r           - real parts of points 0..31
//            in1_i..in32_i           - imaginary parts of points 0..31
//            out_valid / out_ready   - per-beat handshake
//            out_r, out_i            - current complex sample
//            out_index               - zero-based point index of the sample
//            out_last                - high on the 32nd beat of a frame
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_out_serializer #(
  parameter int N     = 16,
  parameter int ORDER = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in1_r,  in2_r,  in3_r,  in4_r,  in5_r,  in6_r,  in7_r,  in8_r,
  input  logic [N-1:0] in9_r,  in10_r, in11_r, in12_r, in13_r, in14_r, in15_r, in16_r,
  input  logic [N-1:0] in17_r, in18_r, in19_r, in20_r, in21_r, in22_r, in23_r, in24_r,
  input  logic [N-1:0] in25_r, in26_r, in27_r, in28_r, in29_r, in30_r, in31_r, in32_r,
  input  logic [N-1:0] in1_i,  in2_i,  in3_i,  in4_i,  in5_i,  in6_i,  in7_i,  in8_i,
  input  logic [N-1:0] in9_i,  in10_i, in11_i, in12_i, in13_i, in14_i, in15_i, in16_i,
  input  logic [N-1:0] in17_i, in18_i, in19_i, in20_i, in21_i, in22_i, in23_i, in24_i,
  input  logic [N-1:0] in25_i, in26_i, in27_i, in28_i, in29_i, in30_i, in31_i, in32_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_r,
  output logic [N-1:0] out_i,
  output logic [4:0]   out_index,
  output logic         out_last
);

  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_state_e;

  // Gather the flat input ports into arrays indexed by point number
  logic [N-1:0] in_r_w [32];
  logic [N-1:0] in_i_w [32];

  assign in_r_w[0]  = in1_r;  assign in_r_w[1]  = in2_r;  assign in_r_w[2]  = in3_r;  assign in_r_w[3]  = in4_r;
  assign in_r_w[4]  = in5_r;  assign in_r_w[5]  = in6_r;  assign in_r_w[6]  = in7_r;  assign in_r_w[7]  = in8_r;
  assign in_r_w[8]  = in9_r;  assign in_r_w[9]  = in10_r; assign in_r_w[10] = in11_r; assign in_r_w[11] = in12_r;
  assign in_r_w[12] = in13_r; assign in_r_w[13] = in14_r; assign in_r_w[14] = in15_r; assign in_r_w[15] = in16_r;
  assign in_r_w[16] = in17_r; assign in_r_w[17] = in18_r; assign in_r_w[18] = in19_r; assign in_r_w[19] = in20_r;
  assign in_r_w[20] = in21_r; assign in_r_w[21] = in22_r; assign in_r_w[22] = in23_r; assign in_r_w[23] = in24_r;
  assign in_r_w[24] = in25_r; assign in_r_w[25] = in26_r; assign in_r_w[26] = in27_r; assign in_r_w[27] = in28_r;
  assign in_r_w[28] = in29_r; assign in_r_w[29] = in30_r; assign in_r_w[30] = in31_r; assign in_r_w[31] = in32_r;

  assign in_i_w[0]  = in1_i;  assign in_i_w[1]  = in2_i;  assign in_i_w[2]  = in3_i;  assign in_i_w[3]  = in4_i;
  assign in_i_w[4]  = in5_i;  assign in_i_w[5]  = in6_i;  assign in_i_w[6]  = in7_i;  assign in_i_w[7]  = in8_i;
  assign in_i_w[8]  = in9_i;  assign in_i_w[9]  = in10_i; assign in_i_w[10] = in11_i; assign in_i_w[11] = in12_i;
  assign in_i_w[12] = in13_i; assign in_i_w[13] = in14_i; assign in_i_w[14] = in15_i; assign in_i_w[15] = in16_i;
  assign in_i_w[16] = in17_i; assign in_i_w[17] = in18_i; assign in_i_w[18] = in19_i; assign in_i_w[19] = in20_i;
  assign in_i_w[20] = in21_i; assign in_i_w[21] = in22_i; assign in_i_w[22] = in23_i; assign in_i_w[23] = in24_i;
  assign in_i_w[24] = in25_i; assign in_i_w[25] = in26_i; assign in_i_w[26] = in27_i; assign in_i_w[27] = in28_i;
  assign in_i_w[28] = in29_i; assign in_i_w[29] = in30_i; assign in_i_w[30] = in31_i; assign in_i_w[31] = in32_i;

  // Storage and control state
  logic [N-1:0] bank_r_q [2][32];
  logic [N-1:0] bank_i_q [2][32];
  bank_state_e  state_q  [2];
  bank_state_e  state_d  [2];
  logic         wr_bank_q, wr_bank_d;
  logic         rd_bank_q, rd_bank_d;
  logic [4:0]   cnt_q, cnt_d;

  logic         capture_w;
  logic         beat_w;
  logic         last_beat_w;
  logic [4:0]   addr_w;

  // Read address: beat counter as-is, or with its five bits mirrored
  if (ORDER == 1) begin : g_bitrev
    assign addr_w = {cnt_q[0], cnt_q[1], cnt_q[2], cnt_q[3], cnt_q[4]};
  end else begin : g_natural
    assign addr_w = cnt_q;
  end

  // Next-state and outputs. A capture and a final beat in the same cycle
  // always target different banks: capture needs wr_bank empty, the final
  // beat needs rd_bank full.
  always_comb begin
    state_d[0]  = state_q[0];
    state_d[1]  = state_q[1];
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    cnt_d       = cnt_q;
    in_ready    = (state_q[wr_bank_q] == BANK_EMPTY);
    out_valid   = (state_q[rd_bank_q] == BANK_FULL);
    out_r       = '0;
    out_i       = '0;
    out_index   = '0;
    out_last    = 1'b0;

    capture_w   = in_valid && in_ready;
    beat_w      = out_valid && out_ready;
    last_beat_w = beat_w && (cnt_q == 5'd31);

    if (out_valid) begin
      out_r     = bank_r_q[rd_bank_q][addr_w];
      out_i     = bank_i_q[rd_bank_q][addr_w];
      out_index = addr_w;
      out_last  = (cnt_q == 5'd31);
    end

    if (capture_w) begin
      state_d[wr_bank_q] = BANK_FULL;
      wr_bank_d          = ~wr_bank_q;
    end

    if (last_beat_w) begin
      state_d[rd_bank_q] = BANK_EMPTY;
      rd_bank_d          = ~rd_bank_q;
      cnt_d              = 5'd0;
    end else if (beat_w) begin
      cnt_d              = cnt_q + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q[0] <= BANK_EMPTY;
      state_q[1] <= BANK_EMPTY;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      cnt_q      <= 5'd0;
    end else begin
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      cnt_q      <= cnt_d;
    end
  end

  // Sample storage is never read while its bank is empty, so it carries no reset
  always_ff @(posedge clk) begin
    if (capture_w) begin
      for (int k = 0; k < 32; k++) begin
        bank_r_q[wr_bank_q][k] <= in_r_w[k];
        bank_i_q[wr_bank_q][k] <= in_i_w[k];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fft_out_serializer.sv
// ============================================================================
// Module   : tb_fft_out_serializer
// Purpose  : Self-checking bench for fft_out_serializer. Two instances
//            (natural and bit-reversed order) share all inputs and are
//            compared every cycle against a queue of expected beats.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fft_out_serializer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] fr_r [32];
  logic [15:0] fr_i [32];

  logic        rdy0, rdy1, ov0, ov1, ol0, ol1;
  logic [15:0] or0, or1, oi0, oi1;
  logic [4:0]  ox0, ox1;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] r;
    logic [15:0] i;
    logic [4:0]  idx;
    logic        last;
  } beat_t;

  // Remaining expected beats, in output order, for each read order
  beat_t q0[$];
  beat_t q1[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fft_out_serializer #(.N(16), .ORDER(0)) u_nat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
    .in1_r(fr_r[0]),   .in2_r(fr_r[1]),   .in3_r(fr_r[2]),   .in4_r(fr_r[3]),
    .in5_r(fr_r[4]),   .in6_r(fr_r[5]),   .in7_r(fr_r[6]),   .in8_r(fr_r[7]),
    .in9_r(fr_r[8]),   .in10_r(fr_r[9]),  .in11_r(fr_r[10]), .in12_r(fr_r[11]),
    .in13_r(fr_r[12]), .in14_r(fr_r[13]), .in15_r(fr_r[14]), .in16_r(fr_r[15]),
    .in17_r(fr_r[16]), .in18_r(fr_r[17]), .in19_r(fr_r[18]), .in20_r(fr_r[19]),
    .in21_r(fr_r[20]), .in22_r(fr_r[21]), .in23_r(fr_r[22]), .in24_r(fr_r[23]),
    .in25_r(fr_r[24]), .in26_r(fr_r[25]), .in27_r(fr_r[26]), .in28_r(fr_r[27]),
    .in29_r(fr_r[28]), .in30_r(fr_r[29]), .in31_r(fr_r[30]), .in32_r(fr_r[31]),
    .in1_i(fr_i[0]),   .in2_i(fr_i[1]),   .in3_i(fr_i[2]),   .in4_i(fr_i[3]),
    .in5_i(fr_i[4]),   .in6_i(fr_i[5]),   .in7_i(fr_i[6]),   .in8_i(fr_i[7]),
    .in9_i(fr_i[8]),   .in10_i(fr_i[9]),  .in11_i(fr_i[10]), .in12_i(fr_i[11]),
    .in13_i(fr_i[12]), .in14_i(fr_i[13]), .in15_i(fr_i[14]), .in16_i(fr_i[15]),
    .in17_i(fr_i[16]), .in18_i(fr_i[17]), .in19_i(fr_i[18]), .in20_i(fr_i[19]),
    .in21_i(fr_i[20]), .in22_i(fr_i[21]), .in23_i(fr_i[22]), .in24_i(fr_i[23]),
    .in25_i(fr_i[24]), .in26_i(fr_i[25]), .in27_i(fr_i[26]), .in28_i(fr_i[27]),
    .in29_i(fr_i[28]), .in30_i(fr_i[29]), .in31_i(fr_i[30]), .in32_i(fr_i[31]),
    .out_valid(ov0), .out_ready(out_ready), .out_r(or0), .out_i(oi0),
    .out_index(ox0), .out_last(ol0)
  );

  fft_out_serializer #(.N(16), .ORDER(1)) u_rev (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
    .in1_r(fr_r[0]),   .in2_r(fr_r[1]),   .in3_r(fr_r[2]),   .in4_r(fr_r[3]),
    .in5_r(fr_r[4]),   .in6_r(fr_r[5]),   .in7_r(fr_r[6]),   .in8_r(fr_r[7]),
    .in9_r(fr_r[8]),   .in10_r(fr_r[9]),  .in11_r(fr_r[10]), .in12_r(fr_r[11]),
    .in13_r(fr_r[12]), .in14_r(fr_r[13]), .in15_r(fr_r[14]), .in16_r(fr_r[15]),
    .in17_r(fr_r[16]), .in18_r(fr_r[17]), .in19_r(fr_r[18]), .in20_r(fr_r[19]),
    .in21_r(fr_r[20]), .in22_r(fr_r[21]), .in23_r(fr_r[22]), .in24_r(fr_r[23]),
    .in25_r(fr_r[24]), .in26_r(fr_r[25]), .in27_r(fr_r[26]), .in28_r(fr_r[27]),
    .in29_r(fr_r[28]), .in30_r(fr_r[29]), .in31_r(fr_r[30]), .in32_r(fr_r[31]),
    .in1_i(fr_i[0]),   .in2_i(fr_i[1]),   .in3_i(fr_i[2]),   .in4_i(fr_i[3]),
    .in5_i(fr_i[4]),   .in6_i(fr_i[5]),   .in7_i(fr_i[6]),   .in8_i(fr_i[7]),
    .in9_i(fr_i[8]),   .in10_i(fr_i[9]),  .in11_i(fr_i[10]), .in12_i(fr_i[11]),
    .in13_i(fr_i[12]), .in14_i(fr_i[13]), .in15_i(fr_i[14]), .in16_i(fr_i[15]),
    .in17_i(fr_i[16]), .in18_i(fr_i[17]), .in19_i(fr_i[18]), .in20_i(fr_i[19]),
    .in21_i(fr_i[20]), .in22_i(fr_i[21]), .in23_i(fr_i[22]), .in24_i(fr_i[23]),
    .in25_i(fr_i[24]), .in26_i(fr_i[25]), .in27_i(fr_i[26]), .in28_i(fr_i[27]),
    .in29_i(fr_i[28]), .in30_i(fr_i[29]), .in31_i(fr_i[30]), .in32_i(fr_i[31]),
    .out_valid(ov1), .out_ready(out_ready), .out_r(or1), .out_i(oi1),
    .out_index(ox1), .out_last(ol1)
  );

  // Bit-reverse a 5-bit index by rebuilding it bit by bit
  function automatic logic [4:0] rev5(input int v);
    int r;
    r = 0;
    for (int b = 0; b < 5; b++)
      if (((v >> b) & 1) == 1) r = r + (1 << (4 - b));
    return r[4:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // A frame occupies a bank until its last beat is accepted
  function automatic int frames_held();
    return (q0.size() + 31) / 32;
  endfunction

  task automatic push_frame();
    int a;
    for (int k = 0; k < 32; k++) begin
      q0.push_back('{r: fr_r[k], i: fr_i[k], idx: 5'(k), last: (k == 31)});
      a = int'(rev5(k));
      q1.push_back('{r: fr_r[a], i: fr_i[a], idx: 5'(a), last: (k == 31)});
    end
  endtask

  task automatic check_outputs();
    logic  ev;
    beat_t e0, e1;
    ev = (q0.size() > 0);
    e0 = ev ? q0[0] : '0;
    e1 = ev ? q1[0] : '0;
    chk("nat_in_ready", 32'(rdy0), 32'(frames_held() < 2));
    chk("rev_in_ready", 32'(rdy1), 32'(frames_held() < 2));
    chk("nat_out_valid", 32'(ov0), 32'(ev));
    chk("rev_out_valid", 32'(ov1), 32'(ev));
    chk("nat_out_r", 32'(or0), 32'(e0.r));
    chk("rev_out_r", 32'(or1), 32'(e1.r));
    chk("nat_out_i", 32'(oi0), 32'(e0.i));
    chk("rev_out_i", 32'(oi1), 32'(e1.i));
    chk("nat_out_index", 32'(ox0), 32'(e0.idx));
    chk("rev_out_index", 32'(ox1), 32'(e1.idx));
    chk("nat_out_last", 32'(ol0), 32'(e0.last));
    chk("rev_out_last", 32'(ol1), 32'(e1.last));
  endtask

  // Called just after a falling edge with inputs already set: check, then
  // let one rising edge pass and advance the reference model.
  task automatic cycle(output bit acc);
    bit bt;
    if (!rst) begin
      q0.delete();
      q1.delete();
    end
    check_outputs();
    acc = rst && in_valid && (frames_held() < 2);
    bt  = rst && out_ready && (q0.size() > 0);
    @(posedge clk);
    if (bt) begin
      void'(q0.pop_front());
      void'(q1.pop_front());
    end
    if (acc) push_frame();
    @(negedge clk);
  endtask

  task automatic rand_frame();
    for (int k = 0; k < 32; k++) begin
      fr_r[k] = 16'($urandom);
      fr_i[k] = 16'($urandom);
    end
  endtask

  task automatic extreme_frame();
    for (int k = 0; k < 32; k++) begin
      fr_r[k] = ($urandom % 2 == 0) ? 16'h8000 : 16'h7FFF;
      fr_i[k] = ($urandom % 2 == 0) ? 16'h8000 : 16'h7FFF;
    end
  endtask

  initial begin
    bit a;
    int nacc;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    for (int k = 0; k < 32; k++) begin fr_r[k] = '0; fr_i[k] = '0; end
    #2 rst = 1'b0;
    @(negedge clk);
    cycle(a);
    cycle(a);
    rst = 1'b1;
    cycle(a);

    // Single ramp frame: real = K, imag = -K for port K
    for (int k = 0; k < 32; k++) begin
      fr_r[k] = 16'(k + 1);
      fr_i[k] = 16'(-(k + 1));
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    cycle(a);
    chk("ramp_accept", 32'(a), 32'd1);
    in_valid = 1'b0;
    for (int c = 0; c < 40; c++) cycle(a);

    // Three frames offered back to back
    nacc = 0;
    rand_frame();
    in_valid = 1'b1;
    for (int c = 0; c < 200 && nacc < 3; c++) begin
      cycle(a);
      if (a) begin
        nacc++;
        rand_frame();
      end
    end
    chk("b2b_accepted", 32'(nacc), 32'd3);
    in_valid = 1'b0;
    for (int c = 0; c < 110; c++) cycle(a);

    // Random backpressure with saturated-value frames; source holds until taken
    extreme_frame();
    for (int c = 0; c < 500; c++) begin
      if (!in_valid) begin
        in_valid = ($urandom % 2 == 0);
        extreme_frame();
      end
      out_ready = ($urandom % 3 != 0);
      cycle(a);
      if (a) in_valid = 1'b0;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 80; c++) cycle(a);

    // Fill both banks while stalled; third offer must wait
    out_ready = 1'b0;
    nacc = 0;
    rand_frame();
    in_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      cycle(a);
      if (a) begin
        nacc++;
        rand_frame();
      end
    end
    chk("fill_accepted", 32'(nacc), 32'd2);
    out_ready = 1'b1;
    for (int c = 0; c < 60 && in_valid; c++) begin
      cycle(a);
      if (a) in_valid = 1'b0;
    end
    chk("third_accepted", 32'(in_valid), 32'd0);
    for (int c = 0; c < 110; c++) cycle(a);

    // Asynchronous reset after ten beats of a frame
    rand_frame();
    in_valid = 1'b1;
    cycle(a);
    in_valid = 1'b0;
    for (int c = 0; c < 10; c++) cycle(a);
    #1 rst = 1'b0;
    #1 cycle(a);
    cycle(a);
    rst = 1'b1;
    cycle(a);
    rand_frame();
    in_valid = 1'b1;
    cycle(a);
    in_valid = 1'b0;
    for (int c = 0; c < 40; c++) cycle(a);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
